stream_fifo: RTL

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/stream_fifo.sv | 90 +++++++++
 1 files changed

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with occupancy level and almost-full/empty flags.
// Optional synchronous queue clear is enabled by defining STREAM_FIFO_FLUSH_EN.
module stream_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef STREAM_FIFO_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       inp_val,
  output logic                       inp_rdy,
  output logic [WIDTH-1:0]           data_out,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_TH);
  localparam logic [LW-1:0] AEMPTY_LVL = LW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             clear;
  logic             push;
  logic             pop;

`ifdef STREAM_FIFO_FLUSH_EN
  assign clear = rst || flush;
`else
  assign clear = rst;
`endif

  // Handshakes depend only on registered occupancy, so a full FIFO never accepts
  // a push even when a pop happens in the same cycle.
  assign inp_rdy      = (level_q != FULL_LVL);
  assign out_val      = (level_q != '0);
  assign push         = inp_val && inp_rdy && !clear;
  assign pop          = out_val && out_rdy && !clear;
  assign data_out     = mem[rd_ptr];
  assign level        = level_q;
  assign almost_full  = (level_q >= AFULL_LVL);
  assign almost_empty = (level_q <= AEMPTY_LVL);

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      level_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
